// File: rtl/idata_bus_pkg.sv
// idata_bus_pkg: shared types and helpers for the internal-data bus arbiter.
// Holds the lock FSM state type, master-count limits and one-hot decode.
package idata_bus_pkg;

    typedef enum logic [0:0] {
        IDLE,
        LOCKED
    } arb_state_t;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    function automatic logic [IDX_W-1:0] onehot_to_idx(
        input logic [MAX_REQ-1:0] oh
    );
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx |= IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/idata_bus_arbiter_rr_picker.sv
// rr_picker: round-robin priority encoder, first requester at or after ptr.
// Ports: req (N requests), ptr (start index 0..N-1), gnt (one-hot winner).
module rr_picker
    import idata_bus_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_gnt;

    // Rotate so ptr lands on bit 0, keep the lowest set bit, rotate back.
    always_comb begin
        rot     = N'({req, req} >> ptr);
        rot_gnt = rot & (~rot + N'(1));
        gnt     = N'(({rot_gnt, rot_gnt} << ptr) >> N);
    end

endmodule

// File: rtl/idata_bus_arbiter.sv
// idata_bus_arbiter: shares the internal-data port (RAM + SFR window) among
// NUM_REQ masters. Master 0 (CPU) has fixed priority, the rest round-robin.
// One access issued per clock, read data returned to the issuing master two
// clocks after its grant; req_lock holds ownership for read-modify-write.
// Optional macro IDBUS_AGE_EN: per-peripheral wait counters that override
// CPU priority once a peripheral has waited MAX_WAIT cycles.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req/req_we/req_lock            per-master request, write, lock
//   req_addr/req_wdata             packed per-master address / write data
//   gnt, rvalid, rdata             grant, read-valid (one-hot), read data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata            downstream RAM/SFR access port
module idata_bus_arbiter
    import idata_bus_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata
);

    localparam int NP = NUM_REQ - 1;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ ||
        MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_param_chk
        $error("idata_bus_arbiter: parameter out of range");
    end

    arb_state_t         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_base;
    logic [NP-1:0]      rr_gnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] tag;
    logic [IDX_W-1:0]   win_idx;
    logic               sel_we;
    logic               sel_lock;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;

    // rr_ptr counts in master indices (1..NUM_REQ-1); the picker is 0-based.
    assign rr_base = rr_ptr - IDX_W'(1);

    rr_picker #(
        .N (NP)
    ) u_rr_picker (
        .req (req[NUM_REQ-1:1]),
        .ptr (rr_base),
        .gnt (rr_gnt)
    );

`ifdef IDBUS_AGE_EN
    logic [3:0]         age [1:NUM_REQ-1];
    logic [NUM_REQ-1:0] aged;
    logic [NUM_REQ-1:0] aged_first;

    always_comb begin
        aged = '0;
        for (int i = 1; i < NUM_REQ; i++) begin
            aged[i] = req[i] && (age[i] == 4'(MAX_WAIT));
        end
        aged_first = aged & (~aged + NUM_REQ'(1));
    end

    // Counters saturate so a peripheral stalled by a lock stays aged.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_REQ; i++) begin
            if (reset) begin
                age[i] <= '0;
            end else if (gnt[i]) begin
                age[i] <= '0;
            end else if (req[i] && age[i] != 4'(MAX_WAIT)) begin
                age[i] <= age[i] + 4'd1;
            end
        end
    end
`endif

    always_comb begin
        arb_gnt = '0;
        if (state == LOCKED) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == int'(owner)) arb_gnt[i] = req[i];
            end
        end
`ifdef IDBUS_AGE_EN
        else if (|aged) begin
            arb_gnt = aged_first;
        end
`endif
        else if (req[0]) begin
            arb_gnt[0] = 1'b1;
        end else begin
            arb_gnt = {rr_gnt, 1'b0};
        end
    end

    assign gnt = reset ? '0 : arb_gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_we    |= req_we[i];
                sel_lock  |= req_lock[i];
                sel_addr  |= req_addr[i*AW +: AW];
                sel_wdata |= req_wdata[i*DW +: DW];
            end
        end
        win_idx = onehot_to_idx(MAX_REQ'(gnt));
    end

    // Issue and return stages; tag is the one-hot owner of the issued access.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tag       <= '0;
            rvalid    <= '0;
        end else begin
            rvalid <= (mem_en && !mem_we) ? tag : '0;
            if (|gnt) begin
                mem_en    <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                tag       <= gnt;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
        end
    end

    assign rdata = (|rvalid) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= IDX_W'(1);
        end else begin
            if (|gnt[NUM_REQ-1:1]) begin
                rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ?
                          IDX_W'(1) : win_idx + IDX_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (|gnt && sel_lock) begin
                        state <= LOCKED;
                        owner <= win_idx;
                    end
                end
                LOCKED: begin
                    if (|gnt && !sel_lock) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idata_bus_arbiter.sv
// tb_idata_bus_arbiter: directed scenarios plus randomized traffic against
// a behavioural arbiter/memory model.
module tb_idata_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MW = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, req_we, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            mem_clr;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] dmem [256];
    logic       dwr  [256];
    logic [7:0] ref_mem [256];

    idata_bus_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h30) ? 8'h5A : (a ^ 8'h6C);
    endfunction

    // Downstream RAM: read data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) dwr[i] <= 1'b0;
        end else if (mem_en) begin
            if (mem_we) begin
                dmem[mem_addr] <= mem_wdata;
                dwr[mem_addr]  <= 1'b1;
            end else begin
                mem_rdata <= dwr[mem_addr] ? dmem[mem_addr] : init_val(mem_addr);
            end
        end
    end

    task automatic set_req(input int i, input logic we, input logic lk,
                           input logic [7:0] a, input logic [7:0] d);
        req[i] = 1'b1;
        req_we[i] = we;
        req_lock[i] = lk;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic drop(input int i);
        req[i] = 1'b0;
        req_we[i] = 1'b0;
        req_lock[i] = 1'b0;
    endtask

    task automatic idle_all();
        req = '0;
        req_we = '0;
        req_lock = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle_all();
        repeat (n) next();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_clr = 1'b1;
        set_req(1, 1'b0, 1'b0, 8'h11, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rst_gnt: got %b exp 000", gnt); end
            n_chk++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid: got %b exp 000", rvalid); end
            n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b exp 0", mem_en); end
            next();
        end
        reset = 1'b0;
        mem_clr = 1'b0;
        drop(1);
        set_req(0, 1'b0, 1'b0, 8'h30, 8'h00);
        @(negedge clk);
        n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rd_t0_gnt: got %b exp 001", gnt); end
        n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rd_t0_en: got %b exp 0", mem_en); end
        next();
        drop(0);
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_t1_issue: got en=%b we=%b exp en=1 we=0", mem_en, mem_we); end
        n_chk++; if (mem_addr !== 8'h30) begin n_fail++; $display("FAIL rd_t1_addr: got %h exp 30", mem_addr); end
        n_chk++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rd_t1_rvalid: got %b exp 000", rvalid); end
        next();
        @(negedge clk);
        n_chk++; if (rvalid !== 3'b001) begin n_fail++; $display("FAIL rd_t2_rvalid: got %b exp 001", rvalid); end
        n_chk++; if (rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_t2_rdata: got %h exp 5a", rdata); end
        next();
        @(negedge clk);
        n_chk++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rd_t3_rvalid: got %b exp 000", rvalid); end
        next();
    endtask

    task automatic test_cpu_priority();
        set_req(0, 1'b1, 1'b0, 8'h90, 8'hA5);
        set_req(1, 1'b0, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL pri_t0_gnt: got %b exp 001", gnt); end
        next();
        drop(0);
        @(negedge clk);
        n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL pri_t1_gnt: got %b exp 010", gnt); end
        n_chk++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL pri_t1_wr: got en=%b we=%b exp 1 1", mem_en, mem_we); end
        n_chk++; if (mem_addr !== 8'h90 || mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL pri_t1_wdata: got %h/%h exp 90/a5", mem_addr, mem_wdata); end
        next();
        drop(1);
        @(negedge clk);
        n_chk++; if (mem_we !== 1'b0 || mem_addr !== 8'h20) begin n_fail++; $display("FAIL pri_t2_rd: got we=%b addr=%h exp 0/20", mem_we, mem_addr); end
        n_chk++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL pri_t2_rvalid: got %b exp 000", rvalid); end
        next();
        @(negedge clk);
        n_chk++; if (rvalid !== 3'b010) begin n_fail++; $display("FAIL pri_t3_rvalid: got %b exp 010", rvalid); end
        n_chk++; if (rdata !== 8'h4C) begin n_fail++; $display("FAIL pri_t3_rdata: got %h exp 4c", rdata); end
        next();
        @(negedge clk);
        n_chk++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL pri_t4_rvalid: got %b exp 000", rvalid); end
        next();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        logic [N-1:0] hist [8];
        do_reset(1);
        set_req(1, 1'b0, 1'b0, 8'h10, 8'h00);
        set_req(2, 1'b0, 1'b0, 8'h11, 8'h00);
        for (int k = 0; k < 8; k++) begin
            exp_g = (k % 2 == 0) ? 3'b010 : 3'b100;
            hist[k] = exp_g;
            @(negedge clk);
            n_chk++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b exp %b", k, gnt, exp_g); end
            if (k > 0) begin
                n_chk++; if (mem_en !== 1'b1 || mem_addr !== ((k % 2 == 1) ? 8'h10 : 8'h11)) begin n_fail++; $display("FAIL rr_issue[%0d]: got en=%b addr=%h", k, mem_en, mem_addr); end
            end
            if (k > 1) begin
                n_chk++; if (rvalid !== hist[k-2]) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b exp %b", k, rvalid, hist[k-2]); end
            end
            next();
        end
        idle_all();
        repeat (3) next();
    endtask

    task automatic test_lock();
        set_req(1, 1'b0, 1'b1, 8'h25, 8'h00);
        @(negedge clk);
        n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL lk_t0_gnt: got %b exp 010", gnt); end
        next();
        drop(1);
        set_req(0, 1'b0, 1'b0, 8'h25, 8'h00);
        @(negedge clk);
        n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL lk_t1_gnt: got %b exp 000", gnt); end
        next();
        @(negedge clk);
        n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL lk_t2_gnt: got %b exp 000", gnt); end
        n_chk++; if (rvalid !== 3'b010 || rdata !== 8'h49) begin n_fail++; $display("FAIL lk_t2_read: got %b/%h exp 010/49", rvalid, rdata); end
        next();
        set_req(1, 1'b1, 1'b0, 8'h25, 8'h3C);
        @(negedge clk);
        n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL lk_t3_gnt: got %b exp 010", gnt); end
        next();
        drop(1);
        @(negedge clk);
        n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL lk_t4_gnt: got %b exp 001", gnt); end
        next();
        drop(0);
        next();
        @(negedge clk);
        n_chk++; if (rvalid !== 3'b001 || rdata !== 8'h3C) begin n_fail++; $display("FAIL lk_t6_rmw: got %b/%h exp 001/3c", rvalid, rdata); end
        next();
    endtask

    task automatic test_reset_mid();
        set_req(2, 1'b0, 1'b1, 8'h40, 8'h00);
        @(negedge clk);
        n_chk++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL rm_t0_gnt: got %b exp 100", gnt); end
        next();
        drop(2);
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1 || gnt !== 3'b000) begin n_fail++; $display("FAIL rm_t1: got en=%b gnt=%b exp 1/000", mem_en, gnt); end
        next();
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h41, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h42, 8'h00);
        @(negedge clk);
        n_chk++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rm_t2_rvalid: got %b exp 000", rvalid); end
        n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rm_t2_en: got %b exp 0", mem_en); end
        n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rm_t2_gnt: got %b exp 001", gnt); end
        next();
        drop(0);
        @(negedge clk);
        n_chk++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rm_t3_rvalid: got %b exp 000", rvalid); end
        n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rm_t3_gnt: got %b exp 010", gnt); end
        next();
        drop(1);
        @(negedge clk);
        n_chk++; if (rvalid !== 3'b001 || rdata !== 8'h2D) begin n_fail++; $display("FAIL rm_t4_read: got %b/%h exp 001/2d", rvalid, rdata); end
        repeat (2) next();
    endtask

    task automatic test_age();
        logic [N-1:0] exp_g;
        do_reset(1);
        set_req(0, 1'b0, 1'b0, 8'h50, 8'h00);
        set_req(2, 1'b0, 1'b0, 8'h51, 8'h00);
        for (int k = 0; k < 20; k++) begin
`ifdef IDBUS_AGE_EN
            exp_g = (k == MW) ? 3'b100 : 3'b001;
`else
            exp_g = 3'b001;
`endif
            @(negedge clk);
            n_chk++; if (gnt !== exp_g) begin n_fail++; $display("FAIL age_gnt[%0d]: got %b exp %b", k, gnt, exp_g); end
            next();
            if (exp_g[2]) drop(2);
        end
        idle_all();
        repeat (3) next();
    endtask

    task automatic test_random();
        logic       pend [N];
        logic       p_we [N];
        logic       p_lk [N];
        logic [7:0] p_ad [N];
        logic [7:0] p_wd [N];
        int         age [N];
        logic       m_locked;
        int         m_owner, m_rr, w;
        logic       p1_en, p1_we;
        logic [7:0] p1_addr, p1_wdata, p1_rd, p2_data;
        logic [N-1:0] p2_rv, eg;
        logic       found;
        int         idx;
        mem_clr = 1'b1;
        do_reset(2);
        mem_clr = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; p_we[i] = 0; p_lk[i] = 0; p_ad[i] = 0; p_wd[i] = 0; age[i] = 0;
        end
        m_locked = 0; m_owner = 0; m_rr = 1;
        p1_en = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_rd = 0;
        p2_rv = 0; p2_data = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 45) begin
                    pend[i] = 1;
                    p_we[i] = 1'($urandom_range(0, 1));
                    p_lk[i] = ($urandom_range(0, 4) == 0);
                    p_ad[i] = 8'($urandom_range(0, 7));
                    p_wd[i] = 8'($urandom);
                end
                if (pend[i]) set_req(i, p_we[i], p_lk[i], p_ad[i], p_wd[i]);
                else drop(i);
            end
            eg = '0;
            found = 0;
            if (m_locked) begin
                if (pend[m_owner]) eg[m_owner] = 1'b1;
            end else begin
`ifdef IDBUS_AGE_EN
                for (int i = 1; i < N; i++) begin
                    if (!found && pend[i] && age[i] == MW) begin eg[i] = 1'b1; found = 1; end
                end
`endif
                if (!found && pend[0]) begin eg[0] = 1'b1; found = 1; end
                for (int k = 0; k < N - 1; k++) begin
                    idx = 1 + ((m_rr - 1 + k) % (N - 1));
                    if (!found && pend[idx]) begin eg[idx] = 1'b1; found = 1; end
                end
            end
            @(negedge clk);
            n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b exp %b", c, gnt, eg); end
            n_chk++; if (mem_en !== p1_en || mem_we !== (p1_en & p1_we)) begin n_fail++; $display("FAIL rnd_issue[%0d]: got en=%b we=%b exp %b %b", c, mem_en, mem_we, p1_en, p1_en & p1_we); end
            if (p1_en) begin
                n_chk++; if (mem_addr !== p1_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h exp %h", c, mem_addr, p1_addr); end
                if (p1_we) begin
                    n_chk++; if (mem_wdata !== p1_wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h exp %h", c, mem_wdata, p1_wdata); end
                end
            end
            n_chk++; if (rvalid !== p2_rv) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b exp %b", c, rvalid, p2_rv); end
            if (|p2_rv) begin
                n_chk++; if (rdata !== p2_data) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", c, rdata, p2_data); end
            end
            p2_rv = (p1_en && !p1_we) ? p1_rd[N-1:0] : '0;
            p2_data = ref_mem[p1_addr];
            for (int i = 1; i < N; i++) begin
                if (eg[i]) age[i] = 0;
                else if (pend[i] && age[i] < MW) age[i]++;
            end
            p1_en = 0;
            p1_we = 0;
            if (|eg) begin
                w = 0;
                for (int i = 0; i < N; i++) if (eg[i]) w = i;
                p1_en = 1;
                p1_we = p_we[w];
                p1_addr = p_ad[w];
                p1_wdata = p_wd[w];
                p1_rd = 8'(1 << w);
                p2_data = p2_data;
                if (p_we[w]) ref_mem[p_ad[w]] = p_wd[w];
                if (!m_locked && p_lk[w]) begin m_locked = 1; m_owner = w; end
                else if (m_locked && !p_lk[w]) m_locked = 0;
                if (w > 0) m_rr = (w == N - 1) ? 1 : w + 1;
                pend[w] = 0;
            end
            next();
        end
        idle_all();
        repeat (3) next();
    endtask

    initial begin
        reset = 1'b1;
        mem_clr = 1'b1;
        req = '0;
        req_we = '0;
        req_lock = '0;
        req_addr = '0;
        req_wdata = '0;
        test_reset();
        test_cpu_priority();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_age();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
